// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the byte-level UART receiver.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StBreak
  } rx_state_e;

  // Clocks per bit, rounded to nearest.
  function automatic int unsigned clks_per_bit(int unsigned clk_hz, int unsigned baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

  // Bit-timer sizing for the default 100 MHz / 9600 baud build.
  localparam int unsigned DefClksPerBit = clks_per_bit(100_000_000, 9600);
  localparam int unsigned DefCntWidth   = $clog2(DefClksPerBit);

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through byte buffer for the UART receiver output.
// Depth must be a power of two; the caller only pushes when not full or popping.
module uart_rx_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AddrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW:0]   wptr_q;
  logic [AddrW:0]   rptr_q;

  // Storage and pointers; the extra pointer bit separates full from empty.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wptr_q[AddrW-1:0]] <= wdata_i;
        wptr_q <= wptr_q + 1'b1;
      end
      if (pop_i && !empty_o) begin
        rptr_q <= rptr_q + 1'b1;
      end
    end
  end

  // Head of queue is presented combinationally.
  always_comb begin
    rdata_o = mem_q[rptr_q[AddrW-1:0]];
    empty_o = (wptr_q == rptr_q);
    full_o  = (wptr_q[AddrW] != rptr_q[AddrW]) &&
              (wptr_q[AddrW-1:0] == rptr_q[AddrW-1:0]);
  end

endmodule

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver presenting bytes on a valid/ready stream.
// Define UART_RX_FIFO_EN to buffer bytes in a FIFO_DEPTH-entry FWFT FIFO;
// otherwise a single holding register is used.
module uart_rx_byte
  import uart_rx_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       rx,
  output logic [7:0] m_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam int unsigned ClksPerBit = clks_per_bit(CLK_HZ, BAUD);
  localparam int unsigned Half       = ClksPerBit / 2;
  localparam int unsigned CntW       = $clog2(ClksPerBit);

  localparam logic [CntW-1:0] CntFull = CntW'(ClksPerBit - 1);
  localparam logic [CntW-1:0] CntHalf = CntW'(Half - 1);

  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two and at least 2");
  end

  logic            rx_s1_q, rx_s2_q, rx_prev_q;
  rx_state_e       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shreg_q, shreg_d;
  logic            byte_done, stop_err;
  logic            frame_err_q, overrun_q;
  logic            push, pop, full;

  // Two-flop synchronizer plus a delayed copy for falling-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_s1_q   <= rx;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
    end
  end

  // Receiver state, bit timer, bit index and data shifter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
    end
  end

  // Frame sequencing; every sample is taken when the bit timer reaches zero.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shreg_d   = shreg_q;
    byte_done = 1'b0;
    stop_err  = 1'b0;
    if (!ena) begin
      state_d = StIdle;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (rx_prev_q && !rx_s2_q) begin
            state_d = StStart;
            cnt_d   = CntHalf;
          end
        end
        StStart: begin
          if (cnt_q == '0) begin
            if (!rx_s2_q) begin
              state_d = StData;
              cnt_d   = CntFull;
              idx_d   = '0;
            end else begin
              state_d = StIdle;  // start bit did not hold: glitch
            end
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        StData: begin
          if (cnt_q == '0) begin
            shreg_d[idx_q] = rx_s2_q;
            cnt_d          = CntFull;
            idx_d          = idx_q + 3'd1;
            if (idx_q == 3'd7) begin
              state_d = StStop;
            end
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        StStop: begin
          if (cnt_q == '0) begin
            if (rx_s2_q) begin
              byte_done = 1'b1;
              state_d   = StIdle;
            end else begin
              stop_err = 1'b1;
              state_d  = StBreak;
            end
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        StBreak: begin
          if (rx_s2_q) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // A pop in the same cycle frees the slot for the completing byte.
  always_comb begin
    pop  = m_valid && m_ready;
    push = byte_done && (!full || pop);
  end

  // Single-cycle error pulses, registered one cycle after the stop sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= stop_err;
      overrun_q   <= byte_done && full && !pop;
    end
  end

  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

`ifdef UART_RX_FIFO_EN
  logic empty;

  uart_rx_fifo #(
    .Width(8),
    .Depth(FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .push_i (push),
    .wdata_i(shreg_q),
    .pop_i  (pop),
    .rdata_o(m_data),
    .full_o (full),
    .empty_o(empty)
  );

  assign m_valid = !empty;
`else
  logic [7:0] hold_data_q;
  logic       hold_valid_q;

  // Single holding register; data only changes on a push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_data_q  <= 8'h00;
      hold_valid_q <= 1'b0;
    end else if (push) begin
      hold_data_q  <= shreg_q;
      hold_valid_q <= 1'b1;
    end else if (pop) begin
      hold_valid_q <= 1'b0;
    end
  end

  assign full    = hold_valid_q;
  assign m_data  = hold_data_q;
  assign m_valid = hold_valid_q;
`endif

endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed bench for uart_rx_byte at 16 clocks per bit (HALF = 8).
// Bytes are driven one cycle-slot at a time: slot c drives rx just after clock edge c,
// so the stop-bit sample lands on edge 155 and m_valid is seen in slot 155.
module tb_uart_rx_byte;

  logic       clk = 1'b0;
  logic       rst_n, ena, rx, m_ready;
  logic [7:0] m_data;
  logic       m_valid, frame_err, overrun;

  int n_tests = 0;
  int n_fail  = 0;

  // Per-frame observations.
  int         n_xfer, first_valid, n_ferr, ferr_cycle, n_ovr, ovr_cycle;
  logic [7:0] got_data;

  localparam int None = 9999;

  typedef struct {
    logic [7:0] data;
    logic       stop_ok;
    int         tail;
    int         exp_xfer;
    int         exp_ferr;
  } vec_t;

  vec_t vecs[5];

  uart_rx_byte #(
    .CLK_HZ    (1_600_000),
    .BAUD      (100_000),
    .FIFO_DEPTH(4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .rx       (rx),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Drive one frame and record what the DUT does. rdy_mode: 0 never, 1 always,
  // 2 only in slot 154 (pop lands on the stop-sample edge).
  task automatic run_frame(input logic [7:0] d, input logic stop_ok, input int tail,
                           input int cut, input int rdy_mode, input int rst_at,
                           input int ena_at);
    logic [9:0] bits;
    logic       prev_v;
    int         total;
    bits        = {stop_ok, d, 1'b0};
    total       = 160 + tail + 24;
    n_xfer      = 0;
    first_valid = -1;
    n_ferr      = 0;
    ferr_cycle  = -1;
    n_ovr       = 0;
    ovr_cycle   = -1;
    got_data    = 8'h00;
    prev_v      = m_valid;
    for (int c = 0; c < total; c++) begin
      if (c >= cut) rx = 1'b1;
      else if (c < 160) rx = bits[c/16];
      else if (c < 160 + tail) rx = 1'b0;
      else rx = 1'b1;
      case (rdy_mode)
        0:       m_ready = 1'b0;
        1:       m_ready = 1'b1;
        default: m_ready = (c == 154);
      endcase
      rst_n = (c != rst_at);
      ena   = !(c >= ena_at && c < ena_at + 4);
      @(negedge clk);
      if (c == rst_at) begin
        chk("reset mid-frame m_valid", int'(m_valid), 0);
        chk("reset mid-frame m_data", int'(m_data), 0);
        chk("reset mid-frame frame_err", int'(frame_err), 0);
        chk("reset mid-frame overrun", int'(overrun), 0);
      end
      if (m_valid && !prev_v && first_valid < 0) begin
        first_valid = c;
        got_data    = m_data;
      end
      if (m_valid && m_ready) n_xfer++;
      if (frame_err) begin n_ferr++; ferr_cycle = c; end
      if (overrun) begin n_ovr++; ovr_cycle = c; end
      prev_v = m_valid;
      @(posedge clk);
      #1;
    end
    m_ready = 1'b0;
  endtask

  task automatic check_good(input string name, input logic [7:0] d);
    chk({name, " transfers"}, n_xfer, 1);
    chk({name, " m_valid rise slot"}, first_valid, 155);
    chk({name, " m_data"}, int'(got_data), int'(d));
    chk({name, " frame_err pulses"}, n_ferr, 0);
    chk({name, " overrun pulses"}, n_ovr, 0);
  endtask

  // Check the head byte, then pop it with a one-cycle m_ready.
  task automatic drain(input string name, input logic [7:0] exp);
    m_ready = 1'b1;
    @(negedge clk);
    chk({name, " m_valid"}, int'(m_valid), 1);
    chk({name, " m_data"}, int'(m_data), int'(exp));
    @(posedge clk);
    #1;
    m_ready = 1'b0;
  endtask

  task automatic expect_empty(input string name);
    @(negedge clk);
    chk({name, " m_valid"}, int'(m_valid), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{data: 8'hA5, stop_ok: 1'b1, tail: 0,  exp_xfer: 1, exp_ferr: 0};
    vecs[1] = '{data: 8'h7F, stop_ok: 1'b0, tail: 40, exp_xfer: 0, exp_ferr: 1};
    vecs[2] = '{data: 8'hC1, stop_ok: 1'b1, tail: 0,  exp_xfer: 1, exp_ferr: 0};
    vecs[3] = '{data: 8'h00, stop_ok: 1'b1, tail: 0,  exp_xfer: 1, exp_ferr: 0};
    vecs[4] = '{data: 8'hFF, stop_ok: 1'b1, tail: 0,  exp_xfer: 1, exp_ferr: 0};

    rst_n   = 1'b0;
    ena     = 1'b1;
    rx      = 1'b1;
    m_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset m_data", int'(m_data), 0);
    chk("reset m_valid", int'(m_valid), 0);
    chk("reset frame_err", int'(frame_err), 0);
    chk("reset overrun", int'(overrun), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // Table: good frames and a stop-bit error followed by a held-low break.
    for (int i = 0; i < 5; i++) begin
      run_frame(vecs[i].data, vecs[i].stop_ok, vecs[i].tail, None, 1, None, None);
      chk($sformatf("vec%0d transfers", i), n_xfer, vecs[i].exp_xfer);
      chk($sformatf("vec%0d frame_err pulses", i), n_ferr, vecs[i].exp_ferr);
      chk($sformatf("vec%0d overrun pulses", i), n_ovr, 0);
      if (vecs[i].exp_xfer == 1) begin
        chk($sformatf("vec%0d m_valid rise slot", i), first_valid, 155);
        chk($sformatf("vec%0d m_data", i), int'(got_data), int'(vecs[i].data));
      end else begin
        chk($sformatf("vec%0d frame_err slot", i), ferr_cycle, 155);
      end
    end

    // Short low glitch on rx is rejected at the half-bit sample.
    begin
      int gv, gf;
      gv = 0;
      gf = 0;
      for (int c = 0; c < 45; c++) begin
        rx = (c >= 5);
        @(negedge clk);
        if (m_valid) gv++;
        if (frame_err) gf++;
        @(posedge clk);
        #1;
      end
      chk("glitch m_valid cycles", gv, 0);
      chk("glitch frame_err pulses", gf, 0);
    end
    run_frame(8'h3C, 1'b1, 0, None, 1, None, None);
    check_good("after glitch 0x3C", 8'h3C);

    // Overrun with the consumer stalled.
`ifdef UART_RX_FIFO_EN
    run_frame(8'h99, 1'b1, 0, None, 0, None, None);
    chk("fifo 0x99 rise slot", first_valid, 155);
    chk("fifo 0x99 m_data", int'(got_data), 8'h99);
    run_frame(8'h42, 1'b1, 0, None, 0, None, None);
    chk("fifo 0x42 overrun", n_ovr, 0);
    run_frame(8'h11, 1'b1, 0, None, 0, None, None);
    chk("fifo 0x11 overrun", n_ovr, 0);
    run_frame(8'h22, 1'b1, 0, None, 0, None, None);
    chk("fifo 0x22 overrun", n_ovr, 0);
    run_frame(8'h33, 1'b1, 0, None, 0, None, None);
    chk("fifo 5th frame overrun pulses", n_ovr, 1);
    chk("fifo 5th frame overrun slot", ovr_cycle, 155);
    chk("fifo head after overrun", int'(m_data), 8'h99);
    run_frame(8'h5A, 1'b1, 0, None, 2, None, None);
    chk("pop+push same cycle overrun", n_ovr, 0);
    chk("pop+push same cycle transfers", n_xfer, 1);
    drain("fifo drain 1", 8'h42);
    drain("fifo drain 2", 8'h11);
    drain("fifo drain 3", 8'h22);
    drain("fifo drain 4", 8'h5A);
    expect_empty("fifo drained");
`else
    run_frame(8'h99, 1'b1, 0, None, 0, None, None);
    chk("hold 0x99 rise slot", first_valid, 155);
    chk("hold 0x99 m_data", int'(got_data), 8'h99);
    chk("hold 0x99 overrun", n_ovr, 0);
    run_frame(8'h42, 1'b1, 0, None, 0, None, None);
    chk("hold 0x42 overrun pulses", n_ovr, 1);
    chk("hold 0x42 overrun slot", ovr_cycle, 155);
    chk("hold m_data kept", int'(m_data), 8'h99);
    chk("hold m_valid kept", int'(m_valid), 1);
    run_frame(8'h5A, 1'b1, 0, None, 2, None, None);
    chk("pop+push same cycle overrun", n_ovr, 0);
    chk("pop+push same cycle transfers", n_xfer, 1);
    drain("hold drain", 8'h5A);
    expect_empty("hold drained");
`endif

    // Reset in the middle of a frame, with a byte already buffered.
    run_frame(8'h55, 1'b1, 0, None, 0, None, None);
    chk("pre-reset 0x55 m_data", int'(got_data), 8'h55);
    run_frame(8'hE7, 1'b1, 0, 70, 0, 70, None);
    chk("reset abort transfers", n_xfer, 0);
    chk("reset abort m_valid rise", first_valid, -1);
    chk("reset abort frame_err", n_ferr, 0);
    run_frame(8'hB8, 1'b1, 0, None, 1, None, None);
    check_good("after reset 0xB8", 8'hB8);

    // Same abort using ena; the buffered byte survives.
    run_frame(8'h66, 1'b1, 0, None, 0, None, None);
    chk("pre-ena 0x66 m_data", int'(got_data), 8'h66);
    run_frame(8'hE7, 1'b1, 0, 70, 0, None, 70);
    chk("ena abort frame_err", n_ferr, 0);
    chk("ena abort overrun", n_ovr, 0);
    chk("ena abort m_valid kept", int'(m_valid), 1);
    chk("ena abort m_data kept", int'(m_data), 8'h66);
    drain("ena drain", 8'h66);
    expect_empty("ena drained");
    run_frame(8'hB8, 1'b1, 0, None, 1, None, None);
    check_good("after ena 0xB8", 8'hB8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_byte.md
# uart_rx_byte

- Byte-level UART receiver sitting directly upstream of the Trivium cipher core.
- Oversamples the asynchronous serial line, frames 8N1 characters LSB-first, and presents each received byte on a valid/ready stream that the cipher consumes for keystream XOR.
- Flags framing errors and overruns.
- Default configuration: 100 MHz clock, 9600 baud.

## Interface
Parameters:
- CLK_HZ, 100_000_000, system clock frequency in Hz
- BAUD, 9600, line rate in bits/s
- FIFO_DEPTH, 4, output buffer depth when the FIFO is compiled in; must be a power of two, ≥2

Ports:
- clk  in  1  single system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- ena  in  1  receiver enable; low holds the FSM idle
- rx  in  1  serial line, idle high, asynchronous to clk
- m_data  out  8  received byte
- m_valid  out  1  m_data holds an unconsumed byte
- m_ready  in  1  consumer accepts; transfer when m_valid && m_ready
- frame_err  out  1  one-cycle pulse: stop bit sampled low
- overrun  out  1  one-cycle pulse: completed byte dropped, buffer full

## Operation
- CLKS_PER_BIT = (CLK_HZ + BAUD/2) / BAUD, integer; 10417 at the defaults. HALF = CLKS_PER_BIT/2, truncating.
- rx passes through a 2-flop synchronizer (reset to 1) before any use.
- FSM states: IDLE, START, DATA, STOP, BREAK.
  - IDLE: synchronized rx falling edge (prev 1, now 0) -> START; bit counter loads HALF-1.
  - START: at count 0, sample rx. Low -> DATA, counter loads CLKS_PER_BIT-1, bit index 0. High -> IDLE (glitch rejected).
  - DATA: at each count 0, shift the sample into bit[index], LSB first, and reload the counter. After index 7 -> STOP.
  - STOP: at count 0, sample rx. High -> byte completed, -> IDLE. Low -> frame_err pulse, byte discarded, -> BREAK.
  - BREAK: wait for synchronized rx = 1, then -> IDLE.
- ena low: FSM forced to IDLE and counters cleared; any partial frame is discarded. The output buffer is unaffected and keeps draining.
- Completed byte with buffer space free (counting a pop in the same cycle as free space) -> pushed.
- Completed byte with buffer full and no pop this cycle -> byte dropped, overrun pulse. Buffered contents are unchanged.
- m_data is stable while m_valid && !m_ready.

## Timing
- Reset values: m_data 8'h00, m_valid 0, frame_err 0, overrun 0, FSM IDLE, synchronizer 1.
- Sample points: rx pin edge + 2 cycles (sync) + 1 cycle (edge detect) + HALF + k·CLKS_PER_BIT, for k = 0 (start) … 9 (stop).
- m_valid rises the cycle after the stop-bit sample.
- frame_err and overrun assert the cycle after the stop-bit sample, for exactly one cycle.
- Pop takes effect on the clock edge where m_valid && m_ready. The next byte, if buffered, is visible the following cycle (no bubble).
- Reset asserted mid-frame clears everything immediately. The first falling edge after release starts a clean frame.

## Configuration
- UART_RX_FIFO_EN defined: output is a FIFO_DEPTH-entry FIFO, first-word-fall-through. m_valid = not empty; full = FIFO_DEPTH entries held.
- UART_RX_FIFO_EN undefined: single holding register; full = m_valid. FIFO_DEPTH is ignored.
- All other behaviour is identical in both builds.

## Structure
- Package uart_rx_pkg:
  - state enum (IDLE, START, DATA, STOP, BREAK)
  - function computing CLKS_PER_BIT from CLK_HZ and BAUD
  - counter-width localparam via $clog2(CLKS_PER_BIT)
- Sub-module uart_rx_fifo: the FWFT buffer with push/pop/full/empty, instantiated only under UART_RX_FIFO_EN.
- Synchronizer, FSM and shifter live in uart_rx_byte.

## Test plan
Bench uses CLK_HZ=1_600_000, BAUD=100_000 (CLKS_PER_BIT=16, HALF=8) unless noted.
- Frame 0xA5, m_ready=1 -> m_valid high for one cycle with m_data=8'hA5, the cycle after the stop sample; no error pulses.
- rx low for 5 cycles, then high -> START rejects at the half-bit sample; no m_valid, FSM back in IDLE. A following 0x3C frame is received correctly.
- Frame 0x7F with stop bit low, rx held low 40 cycles, then idle -> one frame_err pulse, no m_valid. FSM stays in BREAK until rx=1. A following 0xC1 frame is received correctly.
- m_ready=0, frames 0x99 then 0x42:
  - FIFO off -> m_data holds 8'h99 and overrun pulses once.
  - FIFO on: send 5 frames -> first 4 pop in order, overrun on the 5th.
- Byte completes in the same cycle a full buffer is popped -> new byte accepted, no overrun.
- rst_n pulsed low after 3 data bits of 0xE7 -> all outputs reset at once; a subsequent 0xB8 frame is received correctly. Repeat using ena low instead of reset -> same result, with the existing buffered byte preserved.
